ex_op_sequencer: RTL and testbench
==================================

EX_OP_SEQUENCER -- requirements
Module: ex_op_sequencer

Interface
REQ-001 Parameter WIDTH, default 32: datapath width of src1_i, src2_i and mul_result_o; legal range 8..64.
REQ-002 Parameter ALUOP_W, default 3: width of ALUOp_i; values above 7 decode as illegal.
REQ-003 Port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst_i, input, 1: reset, synchronous and active-high.
REQ-005 Port valid_i, input, 1: operation present on funct_i/ALUOp_i/src*_i.
REQ-006 Port funct_i, input, 6: R-type function field.
REQ-007 Port ALUOp_i, input, ALUOP_W: main-control op class.
REQ-008 Port src1_i, input, WIDTH: multiplicand (rs).
REQ-009 Port src2_i, input, WIDTH: multiplier (rt).
REQ-010 Port ready_o, output, 1: block can accept an operation this cycle.
REQ-011 Port valid_o, output, 1: one-cycle pulse marking the registered outputs as new.
REQ-012 Port ALUCtrl_o, output, 4: registered ALU control code.
REQ-013 Port shamt_select_o, output, 1: registered; selects shamt as ALU operand.
REQ-014 Port jr_o, output, 1: registered; jump-register decoded.
REQ-015 Port illegal_o, output, 1: registered; undecodable operation.
REQ-016 Port mul_result_o, output, WIDTH: low WIDTH bits of the unsigned product; holds until the next multiply completes.

Function
REQ-017 Decode, ALUOp_i=0, by funct_i: 3->1000, 7->1001, 24->0101, 32->0010, 34->0110, 36->0000, 37->0001, 42->0100, 8->0010 with jr_o=1; any other funct -> 1111 with illegal_o=1.
REQ-018 Decode, ALUOp_i=1..7: 0111, 0100, 0010, 0011, 0001, 1011, 1100; ALUOp_i>7 -> 1111 with illegal_o=1.
REQ-019 shamt_select_o = 1 only for ALUOp_i=0, funct_i=3; else 0.
REQ-020 Accept occurs when valid_i=1 and ready_o=1 in the same cycle; inputs are ignored in every other cycle.
REQ-021 FSM states: IDLE, MUL, DONE.
REQ-022 IDLE: ready_o=1; an accepted multiply (ALUOp_i=0, funct_i=24) captures src1_i, src2_i, clears the accumulator, loads counter=WIDTH and goes to MUL.
REQ-023 IDLE: any other accepted op registers its decode; valid_o=1 the next cycle (latency 1); stays IDLE, so back-to-back accepts are allowed every cycle.
REQ-024 MUL: ready_o=0; each cycle, if multiplier bit0=1 then acc += multiplicand (mod 2^WIDTH); multiplicand <<1, multiplier >>1, counter -1; at counter=1 go to DONE.
REQ-025 DONE: mul_result_o<=acc, ALUCtrl_o=0101, valid_o=1 for exactly one cycle, ready_o=0, then IDLE; multiply latency = WIDTH+1 cycles from accept to valid_o.
REQ-026 When not pulsing, valid_o=0; ALUCtrl_o, shamt_select_o, jr_o and illegal_o hold their last values.
REQ-027 A multiply with src2_i=0 still takes the full WIDTH+1 cycles and returns 0.
REQ-028 Overflow beyond WIDTH bits is discarded silently; no flag is produced.
REQ-029 An illegal op is accepted like any single-cycle op (latency 1, valid_o=1) and does not stall.

Reset
REQ-030 With rst_i=1 at a clock edge: state=IDLE, counter=0, valid_o=0, ALUCtrl_o=0000, shamt_select_o=0, jr_o=0, illegal_o=0, mul_result_o=0; ready_o=1 in the cycle after.
REQ-031 Reset during MUL or DONE aborts the multiply; no valid_o is produced for the aborted op.
REQ-032 Reset takes priority over a simultaneous valid_i.

Verification
REQ-033 Reset, then ALUOp_i=0/funct_i=32 accepted -> next cycle valid_o=1, ALUCtrl_o=0010, illegal_o=0.
REQ-034 WIDTH=32; multiply src1=7, src2=6 -> ready_o=0 for 33 cycles, valid_o at cycle 33, mul_result_o=42, ALUCtrl_o=0101.
REQ-035 Multiply 0xFFFFFFFF*2 -> mul_result_o=0xFFFFFFFE; valid_i held high throughout MUL is not accepted and produces no extra valid_o.
REQ-036 funct_i=3 -> ALUCtrl_o=1000, shamt_select_o=1; funct_i=8 -> jr_o=1; funct_i=63 -> ALUCtrl_o=1111, illegal_o=1; all three back-to-back give 3 consecutive valid_o pulses.
REQ-037 rst_i=1 at cycle 10 of a multiply -> no valid_o, ready_o=1 next cycle, mul_result_o=0.
REQ-038 WIDTH=8; multiply 15*17 -> valid_o 9 cycles after accept, mul_result_o=0xFF.

Source files
------------

// File: rtl/ex_op_sequencer.sv
// Execute-stage op sequencer: single-cycle ALU-control decode plus a
// shift-add multiplier that stalls the front end for WIDTH+1 cycles.
module ex_op_sequencer #(
  parameter int WIDTH   = 32,
  parameter int ALUOP_W = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [5:0]         funct_i,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  input  logic [WIDTH-1:0]   src1_i,
  input  logic [WIDTH-1:0]   src2_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [3:0]         ALUCtrl_o,
  output logic               shamt_select_o,
  output logic               jr_o,
  output logic               illegal_o,
  output logic [WIDTH-1:0]   mul_result_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d, mplr_q, mplr_d, acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               valid_q, valid_d;
  logic [3:0]         ctrl_q, ctrl_d;
  logic               shamt_q, shamt_d, jr_q, jr_d, illegal_q, illegal_d;

  logic [3:0]         dec_ctrl;
  logic               dec_shamt, dec_jr, dec_illegal, is_mul, accept;
  logic [31:0]        aluop_ext;

  // Zero-extend so codes above 7 are detectable for any ALUOP_W.
  assign aluop_ext = 32'(ALUOp_i);
  assign is_mul    = (aluop_ext == 32'd0) && (funct_i == 6'd24);
  assign accept    = valid_i && (state_q == IDLE);

  always_comb begin
    dec_ctrl    = 4'b1111;
    dec_illegal = 1'b1;
    dec_shamt   = 1'b0;
    dec_jr      = 1'b0;
    if (aluop_ext == 32'd0) begin
      dec_illegal = 1'b0;
      case (funct_i)
        6'd3:    begin dec_ctrl = 4'b1000; dec_shamt = 1'b1; end
        6'd7:    dec_ctrl = 4'b1001;
        6'd24:   dec_ctrl = 4'b0101;
        6'd32:   dec_ctrl = 4'b0010;
        6'd34:   dec_ctrl = 4'b0110;
        6'd36:   dec_ctrl = 4'b0000;
        6'd37:   dec_ctrl = 4'b0001;
        6'd42:   dec_ctrl = 4'b0100;
        6'd8:    begin dec_ctrl = 4'b0010; dec_jr = 1'b1; end
        default: begin dec_ctrl = 4'b1111; dec_illegal = 1'b1; end
      endcase
    end else begin
      dec_illegal = 1'b0;
      case (aluop_ext)
        32'd1:   dec_ctrl = 4'b0111;
        32'd2:   dec_ctrl = 4'b0100;
        32'd3:   dec_ctrl = 4'b0010;
        32'd4:   dec_ctrl = 4'b0011;
        32'd5:   dec_ctrl = 4'b0001;
        32'd6:   dec_ctrl = 4'b1011;
        32'd7:   dec_ctrl = 4'b1100;
        default: begin dec_ctrl = 4'b1111; dec_illegal = 1'b1; end
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    acc_d     = acc_q;
    result_d  = result_q;
    valid_d   = 1'b0;
    ctrl_d    = ctrl_q;
    shamt_d   = shamt_q;
    jr_d      = jr_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: if (accept) begin
        if (is_mul) begin
          mcand_d = src1_i;
          mplr_d  = src2_i;
          acc_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = MUL;
        end else begin
          ctrl_d    = dec_ctrl;
          shamt_d   = dec_shamt;
          jr_d      = dec_jr;
          illegal_d = dec_illegal;
          valid_d   = 1'b1;
        end
      end
      MUL: begin
        if (mplr_q[0]) acc_d = acc_q + mcand_q;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        result_d  = acc_q;
        ctrl_d    = 4'b0101;
        shamt_d   = 1'b0;
        jr_d      = 1'b0;
        illegal_d = 1'b0;
        valid_d   = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      ctrl_q    <= 4'b0000;
      shamt_q   <= 1'b0;
      jr_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      shamt_q   <= shamt_d;
      jr_q      <= jr_d;
      illegal_q <= illegal_d;
    end
  end

  assign ready_o        = (state_q == IDLE);
  assign valid_o        = valid_q;
  assign ALUCtrl_o      = ctrl_q;
  assign shamt_select_o = shamt_q;
  assign jr_o           = jr_q;
  assign illegal_o      = illegal_q;
  assign mul_result_o   = result_q;

endmodule

// File: tb/tb_ex_op_sequencer.sv
// Directed bench for ex_op_sequencer: a WIDTH=32 instance for decode and
// multiply scenarios, plus a WIDTH=8 instance for the narrow multiply.
module tb_ex_op_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          total = 0;
  int          bad = 0;

  logic        valid_i = 1'b0;
  logic [5:0]  funct_i = '0;
  logic [2:0]  aluop_i = '0;
  logic [31:0] src1_i = '0, src2_i = '0;
  logic        ready_o, valid_o, shamt_o, jr_o, illegal_o;
  logic [3:0]  ctrl_o;
  logic [31:0] mul_o;

  logic        valid8_i = 1'b0;
  logic [5:0]  funct8_i = '0;
  logic [2:0]  aluop8_i = '0;
  logic [7:0]  src18_i = '0, src28_i = '0;
  logic        ready8_o, valid8_o, shamt8_o, jr8_o, illegal8_o;
  logic [3:0]  ctrl8_o;
  logic [7:0]  mul8_o;

  always #5 clk = ~clk;

  ex_op_sequencer #(.WIDTH(32), .ALUOP_W(3)) u_dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .funct_i(funct_i),
    .ALUOp_i(aluop_i), .src1_i(src1_i), .src2_i(src2_i),
    .ready_o(ready_o), .valid_o(valid_o), .ALUCtrl_o(ctrl_o),
    .shamt_select_o(shamt_o), .jr_o(jr_o), .illegal_o(illegal_o),
    .mul_result_o(mul_o)
  );

  ex_op_sequencer #(.WIDTH(8), .ALUOP_W(3)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid8_i), .funct_i(funct8_i),
    .ALUOp_i(aluop8_i), .src1_i(src18_i), .src2_i(src28_i),
    .ready_o(ready8_o), .valid_o(valid8_o), .ALUCtrl_o(ctrl8_o),
    .shamt_select_o(shamt8_o), .jr_o(jr8_o), .illegal_o(illegal8_o),
    .mul_result_o(mul8_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Reset with a simultaneous valid op: reset must win.
    rst = 1'b1; valid_i = 1'b1; aluop_i = 3'd0; funct_i = 6'd3;
    tick();
    rst = 1'b0; valid_i = 1'b0;
    total++;
    if (valid_o !== 1'b0 || ctrl_o !== 4'b0000 || shamt_o !== 1'b0 ||
        jr_o !== 1'b0 || illegal_o !== 1'b0 || mul_o !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b ctrl=%b shamt=%b jr=%b ill=%b mul=%h, want 0 0000 0 0 0 0",
               valid_o, ctrl_o, shamt_o, jr_o, illegal_o, mul_o);
    end
    total++;
    if (ready_o !== 1'b1 || ready8_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %b/%b want 1/1", ready_o, ready8_o);
    end
  endtask

  task automatic test_add();
    valid_i = 1'b1; aluop_i = 3'd0; funct_i = 6'd32;
    tick();
    valid_i = 1'b0;
    total++;
    if (valid_o !== 1'b1 || ctrl_o !== 4'b0010 || illegal_o !== 1'b0) begin
      bad++;
      $display("FAIL add_decode: got valid=%b ctrl=%b ill=%b want 1 0010 0", valid_o, ctrl_o, illegal_o);
    end
    tick();
    total++;
    if (valid_o !== 1'b0 || ctrl_o !== 4'b0010) begin
      bad++;
      $display("FAIL add_hold: got valid=%b ctrl=%b want 0 0010", valid_o, ctrl_o);
    end
  endtask

  task automatic test_decode();
    logic [2:0] ops   [12];
    logic [5:0] fns   [12];
    logic [3:0] exp_c [12];
    ops   = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    fns   = '{6'd7, 6'd34, 6'd36, 6'd37, 6'd42, 6'd3, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
    exp_c = '{4'b1001, 4'b0110, 4'b0000, 4'b0001, 4'b0100, 4'b0111, 4'b0100,
              4'b0010, 4'b0011, 4'b0001, 4'b1011, 4'b1100};
    // One accept per cycle, each checked the cycle after.
    for (int i = 0; i < 12; i++) begin
      valid_i = 1'b1; aluop_i = ops[i]; funct_i = fns[i];
      tick();
      total++;
      if (valid_o !== 1'b1 || ctrl_o !== exp_c[i] || illegal_o !== 1'b0 ||
          shamt_o !== 1'b0 || jr_o !== 1'b0) begin
        bad++;
        $display("FAIL decode_%0d: got valid=%b ctrl=%b ill=%b shamt=%b jr=%b want 1 %b 0 0 0",
                 i, valid_o, ctrl_o, illegal_o, shamt_o, jr_o, exp_c[i]);
      end
    end
    valid_i = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    valid_i = 1'b1; aluop_i = 3'd0; funct_i = 6'd3;
    tick();
    total++;
    if (valid_o !== 1'b1 || ctrl_o !== 4'b1000 || shamt_o !== 1'b1 || jr_o !== 1'b0 || illegal_o !== 1'b0) begin
      bad++;
      $display("FAIL b2b_sll: got valid=%b ctrl=%b shamt=%b jr=%b ill=%b want 1 1000 1 0 0",
               valid_o, ctrl_o, shamt_o, jr_o, illegal_o);
    end
    funct_i = 6'd8;
    tick();
    total++;
    if (valid_o !== 1'b1 || ctrl_o !== 4'b0010 || shamt_o !== 1'b0 || jr_o !== 1'b1 || illegal_o !== 1'b0) begin
      bad++;
      $display("FAIL b2b_jr: got valid=%b ctrl=%b shamt=%b jr=%b ill=%b want 1 0010 0 1 0",
               valid_o, ctrl_o, shamt_o, jr_o, illegal_o);
    end
    funct_i = 6'd63;
    tick();
    valid_i = 1'b0;
    total++;
    if (valid_o !== 1'b1 || ctrl_o !== 4'b1111 || jr_o !== 1'b0 || illegal_o !== 1'b1 || ready_o !== 1'b1) begin
      bad++;
      $display("FAIL b2b_illegal: got valid=%b ctrl=%b jr=%b ill=%b rdy=%b want 1 1111 0 1 1",
               valid_o, ctrl_o, jr_o, illegal_o, ready_o);
    end
    tick();
    total++;
    if (valid_o !== 1'b0 || ctrl_o !== 4'b1111 || illegal_o !== 1'b1) begin
      bad++;
      $display("FAIL b2b_hold: got valid=%b ctrl=%b ill=%b want 0 1111 1", valid_o, ctrl_o, illegal_o);
    end
  endtask

  // Accept a multiply; optionally hold another valid op on the inputs
  // throughout the stall. Checks latency, stall length and result.
  task automatic run_mul(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input bit hold_valid);
    int lat, low;
    valid_i = 1'b1; aluop_i = 3'd0; funct_i = 6'd24; src1_i = a; src2_i = b;
    tick();
    if (hold_valid) begin
      funct_i = 6'd32; src1_i = 32'h1234; src2_i = 32'h5;
    end else begin
      valid_i = 1'b0;
    end
    lat = 0; low = 0;
    while (valid_o !== 1'b1 && lat < 100) begin
      if (ready_o === 1'b0) low++;
      tick();
      lat++;
    end
    valid_i = 1'b0;
    total++;
    if (lat != 33 || low != 33) begin
      bad++;
      $display("FAIL %s_latency: got lat=%0d ready_low=%0d want 33 33", nm, lat, low);
    end
    total++;
    if (mul_o !== exp_r || ctrl_o !== 4'b0101 || ready_o !== 1'b1) begin
      bad++;
      $display("FAIL %s_result: got mul=%h ctrl=%b rdy=%b want %h 0101 1", nm, mul_o, ctrl_o, ready_o, exp_r);
    end
    tick();
    total++;
    if (valid_o !== 1'b0 || mul_o !== exp_r) begin
      bad++;
      $display("FAIL %s_after: got valid=%b mul=%h want 0 %h", nm, valid_o, mul_o, exp_r);
    end
  endtask

  task automatic test_mul();
    run_mul("mul_7x6", 32'd7, 32'd6, 32'd42, 1'b0);
    run_mul("mul_ovf", 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1);
    run_mul("mul_zero", 32'hDEAD_BEEF, 32'd0, 32'd0, 1'b0);
    run_mul("mul_big", 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 1'b0);
  endtask

  task automatic test_reset_mid_mul();
    int pulses;
    valid_i = 1'b1; aluop_i = 3'd0; funct_i = 6'd24; src1_i = 32'd7; src2_i = 32'd6;
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || mul_o !== 32'd0 || ctrl_o !== 4'b0000) begin
      bad++;
      $display("FAIL abort_state: got valid=%b rdy=%b mul=%h ctrl=%b want 0 1 0 0000",
               valid_o, ready_o, mul_o, ctrl_o);
    end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (valid_o === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL abort_no_valid: got %0d pulses want 0", pulses);
    end
  endtask

  task automatic test_width8();
    int lat;
    valid8_i = 1'b1; aluop8_i = 3'd0; funct8_i = 6'd24; src18_i = 8'd15; src28_i = 8'd17;
    tick();
    valid8_i = 1'b0;
    lat = 0;
    while (valid8_o !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
    total++;
    if (lat != 9 || mul8_o !== 8'hFF || ctrl8_o !== 4'b0101) begin
      bad++;
      $display("FAIL w8_mul: got lat=%0d mul=%h ctrl=%b want 9 ff 0101", lat, mul8_o, ctrl8_o);
    end
    // 20*13 = 260 wraps to 4 in 8 bits.
    valid8_i = 1'b1; src18_i = 8'd20; src28_i = 8'd13;
    tick();
    valid8_i = 1'b0;
    lat = 0;
    while (valid8_o !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
    total++;
    if (lat != 9 || mul8_o !== 8'h04) begin
      bad++;
      $display("FAIL w8_wrap: got lat=%0d mul=%h want 9 04", lat, mul8_o);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_decode();
    test_back_to_back();
    test_mul();
    test_reset_mid_mul();
    test_width8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
